// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes, functs and ALU codes.
package mc_ctrl_pkg;

  localparam logic [3:0] S_IF  = 4'd0;
  localparam logic [3:0] S_ID  = 4'd1;
  localparam logic [3:0] S_MA  = 4'd2;
  localparam logic [3:0] S_MRD = 4'd3;
  localparam logic [3:0] S_MWB = 4'd4;
  localparam logic [3:0] S_MWR = 4'd5;
  localparam logic [3:0] S_EXE = 4'd6;
  localparam logic [3:0] S_RWB = 4'd7;
  localparam logic [3:0] S_BR  = 4'd8;
  localparam logic [3:0] S_JMP = 4'd9;
  localparam logic [3:0] S_IEX = 4'd10;
  localparam logic [3:0] S_IWB = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SRL = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [2:0] alu_op;
    logic       illegal;
  } ctrl_t;

  // Immediate-class ops: andi/ori zero-extend, addi sign-extends.
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Instruction fields, status inputs and control outputs between controller and datapath.
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic [1:0] pc_source;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_zero;
  logic [2:0] alu_op;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_en, pc_source, iord, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, ext_zero, alu_op,
           illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_en, pc_source, iord, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, ext_zero, alu_op,
           illegal, state
  );
endinterface

// File: rtl/mc_ctrl_alu_dec.sv
// R-type funct decode into ALU op code, validity and the srl operand-routing flag.
module alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       valid,
  output logic       is_srl
);

  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b1;
    is_srl = 1'b0;
    case (funct)
      F_ADD: alu_op = ALU_ADD;
      F_SUB: alu_op = ALU_SUB;
      F_AND: alu_op = ALU_AND;
      F_OR:  alu_op = ALU_OR;
      F_XOR: alu_op = ALU_XOR;
      F_NOR: alu_op = ALU_NOR;
      F_SLT: alu_op = ALU_SLT;
      F_SRL: begin
        alu_op = ALU_SRL;
        is_srl = 1'b1;
      end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: state register, next-state logic and Moore output decode.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  mc_ctrl_if.master   bus
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [2:0] r_alu_op;
  logic       r_valid;
  logic       r_is_srl;
  logic       op_legal;
  ctrl_t      c;

  alu_dec u_alu_dec (
    .funct  (bus.funct),
    .alu_op (r_alu_op),
    .valid  (r_valid),
    .is_srl (r_is_srl)
  );

  always_comb begin
    case (bus.opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
      OP_ADDI, OP_ANDI, OP_ORI: op_legal = 1'b1;
      default:                  op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:  state_d = bus.mem_ready ? S_ID : S_IF;
      S_ID: begin
        case (bus.opcode)
          OP_RTYPE:                  state_d = S_EXE;
          OP_LW, OP_SW:              state_d = S_MA;
          OP_BEQ:                    state_d = S_BR;
          OP_J:                      state_d = S_JMP;
          OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IEX;
          default:                   state_d = S_IF;
        endcase
      end
      S_MA: begin
        if (bus.opcode == OP_LW)      state_d = S_MRD;
        else if (bus.opcode == OP_SW) state_d = S_MWR;
        else                          state_d = S_IF;
      end
      S_MRD: state_d = bus.mem_ready ? S_MWB : S_MRD;
      S_MWR: state_d = bus.mem_ready ? S_IF : S_MWR;
      S_EXE: state_d = r_valid ? S_RWB : S_IF;
      S_IEX: state_d = S_IWB;
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    c = '0;
    case (state_q)
      S_IF: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALU_ADD;
        c.ir_write  = bus.mem_ready;
        c.pc_write  = bus.mem_ready;
      end
      S_ID: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = ALU_ADD;
        c.illegal   = ~op_legal;
      end
      S_MA: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALU_ADD;
      end
      S_MRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXE: begin
        // srl shifts rt by shamt, which the datapath presents through the immediate path
        c.alu_op    = r_alu_op;
        c.alu_src_a = r_is_srl ? 2'b10 : 2'b01;
        c.alu_src_b = r_is_srl ? 2'b10 : 2'b00;
        c.illegal   = ~r_valid;
      end
      S_RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BR: begin
        c.alu_src_a     = 2'b01;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_IEX: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.alu_op    = imm_alu_op(bus.opcode);
        c.ext_zero  = (bus.opcode != OP_ADDI);
      end
      S_IWB: begin
        c.reg_write = 1'b1;
        c.alu_op    = imm_alu_op(bus.opcode);
        c.ext_zero  = (bus.opcode != OP_ADDI);
      end
      default: ;
    endcase
  end

  // Write enables are held off for as long as reset is asserted, independent of the clock.
  assign bus.pc_en      = rst_n & (c.pc_write | (c.pc_write_cond & bus.zero));
  assign bus.ir_write   = rst_n & c.ir_write;
  assign bus.reg_write  = rst_n & c.reg_write;
  assign bus.mem_write  = rst_n & c.mem_write;
  assign bus.pc_source  = c.pc_source;
  assign bus.iord       = c.iord;
  assign bus.mem_read   = c.mem_read;
  assign bus.reg_dst    = c.reg_dst;
  assign bus.mem_to_reg = c.mem_to_reg;
  assign bus.alu_src_a  = c.alu_src_a;
  assign bus.alu_src_b  = c.alu_src_b;
  assign bus.ext_zero   = c.ext_zero;
  assign bus.alu_op     = c.alu_op;
  assign bus.illegal    = c.illegal;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class through its states with hand-computed controls.
module tb_mc_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   cyc;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;

    // reset with add (opcode 0, funct 100000) already presented
    rst_n         = 1'b0;
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b0;
    bus.opcode    = 6'b000000;
    bus.funct     = 6'b100000;
    #22;
    check("rst_state",     bus.state,     4'd0);
    check("rst_pc_en",     bus.pc_en,     1'b0);
    check("rst_ir_write",  bus.ir_write,  1'b0);
    check("rst_mem_read",  bus.mem_read,  1'b1);
    check("rst_alu_src_b", bus.alu_src_b, 2'b01);
    check("rst_alu_op",    bus.alu_op,    3'b010);
    check("rst_reg_write", bus.reg_write, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("if_ir_write", bus.ir_write, 1'b1);
    check("if_pc_en",    bus.pc_en,    1'b1);
    check("if_mem_read", bus.mem_read, 1'b1);
    cyc = 0;
    tick();
    check("add_id_state", bus.state,     4'd1);
    check("add_id_srcb",  bus.alu_src_b, 2'b11);
    tick();
    check("add_exe_state", bus.state,     4'd6);
    check("add_exe_op",    bus.alu_op,    3'b010);
    check("add_exe_srca",  bus.alu_src_a, 2'b01);
    check("add_exe_srcb",  bus.alu_src_b, 2'b00);
    tick();
    check("add_rwb_state", bus.state,     4'd7);
    check("add_rwb_wr",    bus.reg_write, 1'b1);
    check("add_rwb_dst",   bus.reg_dst,   1'b1);
    tick();
    check("add_end_state", bus.state, 4'd0);
    check("add_cycles",    cyc,       4);

    // srl
    bus.funct = 6'b000010;
    cyc = 0;
    tick(); tick();
    check("srl_exe_state", bus.state,     4'd6);
    check("srl_exe_op",    bus.alu_op,    3'b101);
    check("srl_exe_srca",  bus.alu_src_a, 2'b10);
    check("srl_exe_srcb",  bus.alu_src_b, 2'b10);
    tick(); tick();
    check("srl_cycles", cyc, 4);
    check("srl_end",    bus.state, 4'd0);

    // lw with two wait cycles in MRD
    bus.opcode = 6'b100011;
    cyc = 0;
    tick(); tick();
    check("lw_ma_state", bus.state,     4'd2);
    check("lw_ma_srca",  bus.alu_src_a, 2'b01);
    check("lw_ma_srcb",  bus.alu_src_b, 2'b10);
    bus.mem_ready = 1'b0;
    tick();
    check("lw_mrd1_state", bus.state,    4'd3);
    check("lw_mrd1_iord",  bus.iord,     1'b1);
    check("lw_mrd1_rd",    bus.mem_read, 1'b1);
    tick();
    check("lw_mrd2_state", bus.state, 4'd3);
    check("lw_mrd2_iord",  bus.iord,  1'b1);
    tick();
    bus.mem_ready = 1'b1;
    #1;
    check("lw_mrd3_state", bus.state, 4'd3);
    check("lw_mrd3_iord",  bus.iord,  1'b1);
    tick();
    check("lw_mwb_state", bus.state,      4'd4);
    check("lw_mwb_m2r",   bus.mem_to_reg, 1'b1);
    check("lw_mwb_wr",    bus.reg_write,  1'b1);
    tick();
    check("lw_end",    bus.state, 4'd0);
    check("lw_cycles", cyc,       7);

    // beq taken
    bus.opcode = 6'b000100;
    cyc = 0;
    tick(); tick();
    bus.zero = 1'b1;
    #1;
    check("beq1_state", bus.state,     4'd8);
    check("beq1_pc_en", bus.pc_en,     1'b1);
    check("beq1_psrc",  bus.pc_source, 2'b01);
    check("beq1_op",    bus.alu_op,    3'b110);
    tick();
    check("beq1_cycles", cyc, 3);
    // beq not taken
    cyc = 0;
    tick(); tick();
    bus.zero = 1'b0;
    #1;
    check("beq0_state", bus.state, 4'd8);
    check("beq0_pc_en", bus.pc_en, 1'b0);
    tick();
    check("beq0_end",    bus.state, 4'd0);
    check("beq0_cycles", cyc,       3);

    // j
    bus.opcode = 6'b000010;
    cyc = 0;
    tick(); tick();
    check("j_state", bus.state,     4'd9);
    check("j_pc_en", bus.pc_en,     1'b1);
    check("j_psrc",  bus.pc_source, 2'b10);
    tick();
    check("j_cycles", cyc, 3);

    // ori
    bus.opcode = 6'b001101;
    cyc = 0;
    tick(); tick();
    check("ori_iex_state", bus.state,    4'd10);
    check("ori_iex_op",    bus.alu_op,   3'b001);
    check("ori_iex_ext",   bus.ext_zero, 1'b1);
    check("ori_iex_srcb",  bus.alu_src_b, 2'b10);
    tick();
    check("ori_iwb_state", bus.state,     4'd11);
    check("ori_iwb_wr",    bus.reg_write, 1'b1);
    check("ori_iwb_dst",   bus.reg_dst,   1'b0);
    check("ori_iwb_op",    bus.alu_op,    3'b001);
    tick();
    check("ori_cycles", cyc, 4);

    // addi sign-extends
    bus.opcode = 6'b001000;
    cyc = 0;
    tick(); tick();
    check("addi_op",  bus.alu_op,   3'b010);
    check("addi_ext", bus.ext_zero, 1'b0);
    tick(); tick();
    check("addi_cycles", cyc, 4);

    // illegal opcode
    bus.opcode = 6'b111111;
    cyc = 0;
    tick();
    check("ilop_id_state", bus.state,   4'd1);
    check("ilop_illegal",  bus.illegal, 1'b1);
    tick();
    check("ilop_end",     bus.state,   4'd0);
    check("ilop_pulse",   bus.illegal, 1'b0);
    check("ilop_cycles",  cyc,         2);

    // illegal funct
    bus.opcode = 6'b000000;
    bus.funct  = 6'b111111;
    cyc = 0;
    tick(); tick();
    check("ilfn_state",   bus.state,     4'd6);
    check("ilfn_illegal", bus.illegal,   1'b1);
    check("ilfn_wr",      bus.reg_write, 1'b0);
    tick();
    check("ilfn_end",    bus.state,     4'd0);
    check("ilfn_wr_end", bus.reg_write, 1'b0);
    check("ilfn_cycles", cyc,           3);

    // sw interrupted by reset while waiting in MWR
    bus.opcode = 6'b101011;
    bus.funct  = 6'b100000;
    cyc = 0;
    tick(); tick();
    bus.mem_ready = 1'b0;
    tick();
    check("sw_mwr_state", bus.state,     4'd5);
    check("sw_mwr_wr",    bus.mem_write, 1'b1);
    check("sw_mwr_iord",  bus.iord,      1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("sw_rst_state", bus.state,     4'd0);
    check("sw_rst_wr",    bus.mem_write, 1'b0);
    check("sw_rst_rd",    bus.mem_read,  1'b1);
    bus.mem_ready = 1'b1;
    #1;
    check("sw_rst_irw", bus.ir_write, 1'b0);
    check("sw_rst_pce", bus.pc_en,    1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    tick(); tick();
    tick();
    check("sw2_state", bus.state,     4'd5);
    check("sw2_wr",    bus.mem_write, 1'b1);
    tick();
    check("sw2_end",    bus.state, 4'd0);
    check("sw2_cycles", cyc,       4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
